// File: rtl/assign_trail.sv
// Assignment trail for the DPLL core: LIFO of decisions and implications with
// chronological backtrack (pop implications, flip newest untried decision).
module assign_trail #(
  parameter int VAR_BITS   = 9,
  parameter int DEPTH      = 512,
  parameter int DEPTH_BITS = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push_dec,
  input  logic                  push_imp,
  input  logic [VAR_BITS-1:0]   push_var,
  input  logic                  push_val,
  input  logic [VAR_BITS-1:0]   push_dec_idx,
  input  logic                  backtrack,
  output logic                  busy,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_BITS-1:0] count,
  output logic [VAR_BITS-1:0]   level,
  output logic                  unassign_vld,
  output logic [VAR_BITS-1:0]   unassign_var,
  output logic                  flip_vld,
  output logic [VAR_BITS-1:0]   flip_var,
  output logic                  flip_val,
  output logic                  back_dec_we,
  output logic [VAR_BITS-1:0]   back_dec_idx,
  output logic                  unsat,
  output logic                  overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, POP, FLIP} state_t;
  state_t state;

  logic [VAR_BITS-1:0] mem_var [DEPTH];
  logic                mem_val [DEPTH];
  logic                mem_dec [DEPTH];
  logic                mem_flp [DEPTH];
  logic [VAR_BITS-1:0] mem_idx [DEPTH];

  logic [DEPTH_BITS-1:0] top_ptr;
  logic [AW-1:0]         top_addr;
  logic [AW-1:0]         wr_addr;
  logic [VAR_BITS-1:0]   top_var;
  logic                  top_val;
  logic                  top_dec;
  logic                  top_flp;
  logic [VAR_BITS-1:0]   top_idx;
  logic                  idle_push;
  logic                  do_push;
  logic                  do_flip;

  assign busy  = (state != IDLE);
  assign full  = (count == DEPTH_BITS'(DEPTH));
  assign empty = (count == '0);

  assign top_ptr  = count - DEPTH_BITS'(1);
  assign top_addr = top_ptr[AW-1:0];
  assign wr_addr  = count[AW-1:0];
  assign top_var  = mem_var[top_addr];
  assign top_val  = mem_val[top_addr];
  assign top_dec  = mem_dec[top_addr];
  assign top_flp  = mem_flp[top_addr];
  assign top_idx  = mem_idx[top_addr];

  // Backtrack outranks pushes; decision outranks implication.
  assign idle_push = reset && (state == IDLE) && !backtrack && (push_dec || push_imp);
  assign do_push   = idle_push && !full;
  assign do_flip   = reset && (state == FLIP);

  // Trail storage: written on accepted push, or rewritten in place on flip
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_var[wr_addr] <= push_var;
      mem_val[wr_addr] <= push_val;
      mem_dec[wr_addr] <= push_dec;
      mem_flp[wr_addr] <= 1'b0;
      mem_idx[wr_addr] <= push_dec_idx;
    end else if (do_flip) begin
      mem_val[top_addr] <= ~top_val;
      mem_flp[top_addr] <= 1'b1;
    end
  end

  // Control FSM and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= '0;
      level        <= '0;
      overflow     <= 1'b0;
      unassign_vld <= 1'b0;
      unassign_var <= '0;
      flip_vld     <= 1'b0;
      flip_var     <= '0;
      flip_val     <= 1'b0;
      back_dec_we  <= 1'b0;
      back_dec_idx <= '0;
      unsat        <= 1'b0;
    end else begin
      unassign_vld <= 1'b0;
      flip_vld     <= 1'b0;
      back_dec_we  <= 1'b0;
      unsat        <= 1'b0;
      case (state)
        IDLE: begin
          if (backtrack) begin
            if (empty) unsat <= 1'b1;
            else       state <= POP;
          end else if (idle_push) begin
            if (full) begin
              overflow <= 1'b1;
            end else begin
              count <= count + DEPTH_BITS'(1);
              if (push_dec) level <= level + VAR_BITS'(1);
            end
          end
        end
        POP: begin
          if (top_dec && !top_flp) begin
            state <= FLIP;
          end else begin
            count        <= top_ptr;
            unassign_vld <= 1'b1;
            unassign_var <= top_var;
            if (top_dec) level <= level - VAR_BITS'(1);
            if (top_ptr == '0) begin
              unsat <= 1'b1;
              state <= IDLE;
            end
          end
        end
        FLIP: begin
          flip_vld     <= 1'b1;
          back_dec_we  <= 1'b1;
          flip_var     <= top_var;
          flip_val     <= ~top_val;
          back_dec_idx <= top_idx + VAR_BITS'(1);
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_assign_trail.sv
// Directed self-checking bench for assign_trail: pushes, backtrack/flip,
// unsat, full/overflow, push priority and reset during backtrack.
module tb_assign_trail;

  localparam int VAR_BITS   = 9;
  localparam int DEPTH      = 512;
  localparam int DEPTH_BITS = 10;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  push_dec, push_imp, push_val, backtrack;
  logic [VAR_BITS-1:0]   push_var, push_dec_idx;
  logic                  busy, full, empty;
  logic [DEPTH_BITS-1:0] count;
  logic [VAR_BITS-1:0]   level;
  logic                  unassign_vld, flip_vld, flip_val, back_dec_we, unsat, overflow;
  logic [VAR_BITS-1:0]   unassign_var, flip_var, back_dec_idx;

  int checks   = 0;
  int failures = 0;

  assign_trail #(.VAR_BITS(VAR_BITS), .DEPTH(DEPTH), .DEPTH_BITS(DEPTH_BITS)) dut (
    .clock(clock), .reset(reset),
    .push_dec(push_dec), .push_imp(push_imp), .push_var(push_var), .push_val(push_val),
    .push_dec_idx(push_dec_idx), .backtrack(backtrack),
    .busy(busy), .full(full), .empty(empty), .count(count), .level(level),
    .unassign_vld(unassign_vld), .unassign_var(unassign_var),
    .flip_vld(flip_vld), .flip_var(flip_var), .flip_val(flip_val),
    .back_dec_we(back_dec_we), .back_dec_idx(back_dec_idx),
    .unsat(unsat), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic dec, input logic imp, input int v, input logic val, input int idx);
    push_dec = dec; push_imp = imp;
    push_var = VAR_BITS'(v); push_val = val; push_dec_idx = VAR_BITS'(idx);
    tick();
    push_dec = 1'b0; push_imp = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; push_dec = 1'b0; push_imp = 1'b0; push_val = 1'b0;
    push_var = '0; push_dec_idx = '0; backtrack = 1'b0;

    // 1. reset then idle
    do_reset();
    tick();
    chk("rst_count", count, 0);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {unassign_vld, flip_vld, back_dec_we, unsat}, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_backidx", back_dec_idx, 0);

    // 2. dec v3, imp v7, imp v9, backtrack
    push(1, 0, 3, 1, 0);
    push(0, 1, 7, 1, 0);
    push(0, 1, 9, 0, 0);
    chk("t2_count3", count, 3);
    chk("t2_level1", level, 1);
    backtrack = 1'b1;
    tick();
    backtrack = 1'b0;
    push_imp = 1'b1; push_var = 9'd77;
    chk("t2_busy", busy, 1);
    tick();
    chk("t2_unas1_vld", unassign_vld, 1);
    chk("t2_unas1_var", unassign_var, 9);
    tick();
    chk("t2_unas2_vld", unassign_vld, 1);
    chk("t2_unas2_var", unassign_var, 7);
    tick();
    push_imp = 1'b0;
    chk("t2_noflip_yet", {unassign_vld, flip_vld}, 0);
    tick();
    chk("t2_flip_vld", flip_vld, 1);
    chk("t2_flip_we", back_dec_we, 1);
    chk("t2_flip_var", flip_var, 3);
    chk("t2_flip_val", flip_val, 0);
    chk("t2_back_idx", back_dec_idx, 1);
    chk("t2_count", count, 1);
    chk("t2_level", level, 1);
    chk("t2_busy_done", busy, 0);
    tick();
    chk("t2_flip_pulse", {flip_vld, back_dec_we}, 0);

    // 3. backtrack again: flipped decision popped, unsat
    backtrack = 1'b1;
    tick();
    backtrack = 1'b0;
    tick();
    chk("t3_unas_vld", unassign_vld, 1);
    chk("t3_unas_var", unassign_var, 3);
    chk("t3_unsat", unsat, 1);
    chk("t3_count", count, 0);
    chk("t3_level", level, 0);
    chk("t3_noflip", flip_vld, 0);
    chk("t3_idle", busy, 0);
    tick();
    chk("t3_unsat_pulse", {unsat, unassign_vld, flip_vld}, 0);

    // 4. dec v1, imp v2, dec v5(idx4); flip v5; backtrack again flips v1
    push(1, 0, 1, 1, 0);
    push(0, 1, 2, 1, 0);
    push(1, 0, 5, 0, 4);
    backtrack = 1'b1;
    tick();
    backtrack = 1'b0;
    tick();
    chk("t4a_nopop", unassign_vld, 0);
    tick();
    chk("t4a_flip_vld", flip_vld, 1);
    chk("t4a_flip_var", flip_var, 5);
    chk("t4a_flip_val", flip_val, 1);
    chk("t4a_back_idx", back_dec_idx, 5);
    chk("t4a_level", level, 2);
    chk("t4a_count", count, 3);
    backtrack = 1'b1;
    tick();
    backtrack = 1'b0;
    tick();
    chk("t4b_unas_v5", {unassign_vld, unassign_var}, {1'b1, 9'd5});
    chk("t4b_level_dec", level, 1);
    tick();
    chk("t4b_unas_v2", {unassign_vld, unassign_var}, {1'b1, 9'd2});
    tick();
    tick();
    chk("t4b_flip_vld", flip_vld, 1);
    chk("t4b_flip_var", flip_var, 1);
    chk("t4b_flip_val", flip_val, 0);
    chk("t4b_back_idx", back_dec_idx, 1);
    chk("t4b_level", level, 1);
    chk("t4b_count", count, 1);
    chk("t4b_unsat", unsat, 0);

    // 5. fill to DEPTH, then overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(0, 1, i, i[0], 0);
    chk("t5_full", full, 1);
    chk("t5_count_full", count, DEPTH);
    chk("t5_no_ovf_yet", overflow, 0);
    push(1, 0, 11, 1, 2);
    chk("t5_overflow", overflow, 1);
    chk("t5_count_hold", count, DEPTH);
    chk("t5_level_hold", level, 0);
    tick();
    tick();
    chk("t5_ovf_sticky", overflow, 1);
    do_reset();
    tick();
    chk("t5_ovf_cleared", overflow, 0);
    push(1, 1, 20, 1, 6);
    chk("t5_both_count", count, 1);
    chk("t5_both_level", level, 1);
    backtrack = 1'b1;
    tick();
    backtrack = 1'b0;
    tick();
    tick();
    chk("t5_both_flip", {flip_vld, flip_var, flip_val}, {1'b1, 9'd20, 1'b0});
    chk("t5_both_idx", back_dec_idx, 7);

    // 6. reset during POP, then backtrack on empty
    do_reset();
    push(1, 0, 4, 1, 3);
    push(0, 1, 6, 1, 0);
    push(0, 1, 8, 0, 0);
    backtrack = 1'b1;
    tick();
    backtrack = 1'b0;
    chk("t6_in_pop", busy, 1);
    reset = 1'b0;
    tick();
    chk("t6_count", count, 0);
    chk("t6_level", level, 0);
    chk("t6_idle", busy, 0);
    chk("t6_no_pulse", {unassign_vld, flip_vld, back_dec_we, unsat}, 0);
    reset = 1'b1;
    tick();
    tick();
    chk("t6_quiet", {unassign_vld, flip_vld, back_dec_we, unsat}, 0);
    backtrack = 1'b1;
    tick();
    backtrack = 1'b0;
    chk("t6_unsat", unsat, 1);
    chk("t6_unsat_only", {unassign_vld, flip_vld, back_dec_we, busy}, 0);
    tick();
    chk("t6_unsat_pulse", unsat, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
